pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/hazard_detect.sv | 14 +
 rtl/pipeline_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types: controller state enum and the stage-enable bundle.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } stage_en_t;

  function automatic stage_en_t stage_en_fill(input logic v);
    return '{pc: v, ifid: v, idex: v, exmem: v, memwb: v};
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in ID/EX whose destination feeds the instruction in IF/ID.
module hazard_detect (
  input  logic       idex_dren,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  output logic       load_use
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = idex_dren && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: RUN/DWAIT/HALT FSM plus a redirect-pending flag.
// Optional PIPECTRL_PERF_EN adds saturating stall_cycles / flush_count outputs.
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       exmem_dren,
  input  logic       exmem_dwen,
  input  logic       idex_dren,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       exmem_branch_taken,
  input  logic       ifid_jump,
  input  logic       memwb_halt,
  output logic       pc_en,
  output logic       en_ifid,
  output logic       en_idex,
  output logic       en_exmem,
  output logic       en_memwb,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       flush_exmem,
  output logic       halted
`ifdef PIPECTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  ctrl_state_t state_reg, state_next;
  logic        flag_reg, flag_next;
  stage_en_t   en;
  logic        fl_ifid, fl_idex, fl_exmem;
  logic        load_use;
  logic        dwait_req;

  hazard_detect u_hazard_detect (
    .idex_dren (idex_dren),
    .idex_rt   (idex_rt),
    .ifid_rs   (ifid_rs),
    .ifid_rt   (ifid_rt),
    .load_use  (load_use)
  );

  assign dwait_req = (exmem_dren || exmem_dwen) && !dhit;

  always_comb begin
    en         = stage_en_fill(1'b0);
    fl_ifid    = 1'b0;
    fl_idex    = 1'b0;
    fl_exmem   = 1'b0;
    state_next = state_reg;
    flag_next  = flag_reg;
    if (memwb_halt) begin
      state_next = HALT;
    end else begin
      case (state_reg)
        HALT: ;
        DWAIT: begin
          if (dhit) begin
            en         = stage_en_fill(1'b1);
            state_next = RUN;
          end
        end
        default: begin
          if (dwait_req) begin
            state_next = DWAIT;
          end else if (exmem_branch_taken) begin
            en        = stage_en_fill(1'b1);
            fl_ifid   = 1'b1;
            fl_idex   = 1'b1;
            fl_exmem  = 1'b1;
            flag_next = !ihit;
          end else if (load_use) begin
            en      = stage_en_fill(1'b1);
            en.pc   = 1'b0;
            en.ifid = 1'b0;
            fl_idex = 1'b1;
          end else if (ifid_jump) begin
            en        = stage_en_fill(1'b1);
            fl_ifid   = 1'b1;
            flag_next = !ihit;
          end else if (!ihit) begin
            en      = stage_en_fill(1'b1);
            en.pc   = 1'b0;
            fl_ifid = 1'b1;
          end else begin
            // A fetch that was in flight across a redirect returns now and must be squashed.
            en        = stage_en_fill(1'b1);
            fl_ifid   = flag_reg;
            flag_next = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= RUN;
      flag_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      flag_reg  <= flag_next;
    end
  end

  assign pc_en       = nRST && en.pc;
  assign en_ifid     = nRST && en.ifid;
  assign en_idex     = nRST && en.idex;
  assign en_exmem    = nRST && en.exmem;
  assign en_memwb    = nRST && en.memwb;
  assign flush_ifid  = nRST && fl_ifid;
  assign flush_idex  = nRST && fl_idex;
  assign flush_exmem = nRST && fl_exmem;
  assign halted      = nRST && (state_reg == HALT);

`ifdef PIPECTRL_PERF_EN
  logic [31:0] stall_cycles_reg, flush_count_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles_reg <= 32'd0;
      flush_count_reg  <= 32'd0;
    end else begin
      if (!pc_en && (state_reg != HALT) && (stall_cycles_reg != 32'hFFFF_FFFF))
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if ((flush_ifid || flush_idex || flush_exmem) && (flush_count_reg != 32'hFFFF_FFFF))
        flush_count_reg <= flush_count_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized + directed bench for pipeline_ctrl against a priority-rule reference model.
module tb_pipeline_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, exmem_dren, exmem_dwen, idex_dren;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       exmem_branch_taken, ifid_jump, memwb_halt;
  logic       pc_en, en_ifid, en_idex, en_exmem, en_memwb;
  logic       flush_ifid, flush_idex, flush_exmem, halted;
`ifdef PIPECTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  pipeline_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exmem_dren(exmem_dren), .exmem_dwen(exmem_dwen),
    .idex_dren(idex_dren), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .exmem_branch_taken(exmem_branch_taken), .ifid_jump(ifid_jump), .memwb_halt(memwb_halt),
    .pc_en(pc_en), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem), .halted(halted)
`ifdef PIPECTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state: waiting on data memory, halted, squash owed to a redirected fetch.
  bit          m_wait, m_halt, m_pend;
  int unsigned m_stall, m_flush;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit is_load_use();
    return idex_dren && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
  endfunction

  // {pc, ifid, idex, exmem, memwb, flush_ifid, flush_idex, flush_exmem, halted}
  function automatic logic [8:0] model_out();
    if (!nRST)      return 9'b0;
    if (m_halt)     return 9'b0_0000_000_1;
    if (memwb_halt) return 9'b0;
    if (m_wait)     return dhit ? 9'b11111_000_0 : 9'b0;
    if ((exmem_dren || exmem_dwen) && !dhit) return 9'b0;
    if (exmem_branch_taken) return 9'b11111_111_0;
    if (is_load_use())      return 9'b00111_010_0;
    if (ifid_jump)          return 9'b11111_100_0;
    if (!ihit)              return 9'b01111_100_0;
    return {5'b11111, m_pend, 3'b000};
  endfunction

  task automatic model_clock(input logic [8:0] exp);
    bit redirect;
    if (!nRST) begin
      m_wait = 0; m_halt = 0; m_pend = 0; m_stall = 0; m_flush = 0;
      return;
    end
    if (!exp[8] && !m_halt && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (exp[3:1] != 3'b000 && m_flush != 32'hFFFF_FFFF) m_flush++;
    if (memwb_halt) m_halt = 1;
    else if (m_halt) ;
    else if (m_wait) begin
      if (dhit) m_wait = 0;
    end else if ((exmem_dren || exmem_dwen) && !dhit) m_wait = 1;
    else begin
      redirect = exmem_branch_taken || (!is_load_use() && ifid_jump);
      if (redirect) m_pend = !ihit;
      else if (!is_load_use() && ihit) m_pend = 0;
    end
  endtask

  // Inputs are already applied (after a falling edge); check, then cross one rising edge.
  task automatic cycle();
    logic [8:0] exp, got;
    #1;
    exp = model_out();
    got = {pc_en, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex, flush_exmem, halted};
    $display("cyc %0d rst=%b ih=%b dh=%b dr=%b dw=%b lu=%b br=%b jp=%b hl=%b out=%b",
             cyc, nRST, ihit, dhit, exmem_dren, exmem_dwen, is_load_use(),
             exmem_branch_taken, ifid_jump, memwb_halt, got);
    check("outs", {23'd0, got}, {23'd0, exp});
`ifdef PIPECTRL_PERF_EN
    check("stall_cycles", stall_cycles, m_stall);
    check("flush_count", flush_count, m_flush);
`endif
    @(posedge CLK);
    model_clock(exp);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic set_idle();
    ihit = 1; dhit = 1; exmem_dren = 0; exmem_dwen = 0; idex_dren = 0;
    idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    exmem_branch_taken = 0; ifid_jump = 0; memwb_halt = 0;
  endtask

  task automatic do_reset();
    nRST = 0; cycle(); cycle(); nRST = 1;
  endtask

  initial begin
    set_idle();
    nRST = 0;
    cycle();
    check("reset_en", {27'd0, pc_en, en_ifid, en_idex, en_exmem, en_memwb}, 32'd0);
    check("reset_halted", {31'd0, halted}, 32'd0);
    cycle();
    nRST = 1;

    repeat (5) cycle();

    // Load-use on rs, then the bubble leaves ID/EX
    idex_dren = 1; idex_rt = 5'd4; ifid_rs = 5'd4; ifid_rt = 5'd7;
    #1 check("lu_stall", {29'd0, pc_en, en_ifid, flush_idex}, 32'b001);
    cycle();
    set_idle();
    cycle();

    // Data wait for three cycles, released by dhit
    exmem_dren = 1; dhit = 0;
    repeat (3) cycle();
    dhit = 1;
    #1 check("dwait_release", {27'd0, pc_en, en_ifid, en_idex, en_exmem, en_memwb}, 32'h1F);
    cycle();
    set_idle();
`ifdef PIPECTRL_PERF_EN
    #1 check("perf_stall_lit", stall_cycles, 32'd4);
    check("perf_flush_lit", flush_count, 32'd1);
`endif
    cycle();

    // Branch during a fetch miss, fetch returns two cycles later
    ihit = 0; exmem_branch_taken = 1;
    cycle();
    exmem_branch_taken = 0;
    cycle();
    ihit = 1;
    #1 check("pend_flush", {31'd0, flush_ifid}, 32'd1);
    cycle();
    #1 check("pend_cleared", {31'd0, flush_ifid}, 32'd0);
    cycle();

    // Jump with ihit=1 must not leave a pending squash
    ifid_jump = 1;
    cycle();
    ifid_jump = 0;
    cycle();

    // Halt is sticky until reset
    memwb_halt = 1;
    cycle();
    memwb_halt = 0;
    repeat (3) cycle();
    #1 check("halt_sticky", {31'd0, halted}, 32'd1);
    do_reset();
    check("halt_cleared", {31'd0, halted}, 32'd0);
    cycle();

    for (int i = 0; i < 400; i++) begin
      ihit               = ($urandom_range(0, 3) != 0);
      dhit               = $urandom_range(0, 1);
      exmem_dren         = ($urandom_range(0, 3) == 0);
      exmem_dwen         = ($urandom_range(0, 5) == 0);
      idex_dren          = $urandom_range(0, 1);
      idex_rt            = 5'($urandom_range(0, 3));
      ifid_rs            = 5'($urandom_range(0, 3));
      ifid_rt            = 5'($urandom_range(0, 3));
      exmem_branch_taken = ($urandom_range(0, 7) == 0);
      ifid_jump          = ($urandom_range(0, 7) == 0);
      memwb_halt         = ($urandom_range(0, 63) == 0);
      nRST = !((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
